// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
//
// Registers one execute-stage entry, performs its load/store over a
// request/response memory port with byte-lane alignment and sign/zero
// extension, and hands the final value to writeback.  Non-memory and
// unrecognised opcodes pass straight through with one register of latency.
// Misaligned memory ops never touch memory; they are reported with
// stage4_misaligned=1, result=address, rd=0.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   stage3_*              entry from execute (valid/ready)
//   mem_req_*             memory request (valid/ready), 8-byte aligned addr
//   mem_resp_valid/data   one-cycle read data / store ack, only seen in WAIT
//   stage4_*              entry to writeback (valid/ready)
//   state_dbg             current FSM state (IDLE=0, REQ=1, WAIT=2, OUT=3)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high.  A producer holding valid keeps every payload field stable
// until that edge; valid never depends combinationally on ready.
module memory_stage #(
    parameter int REGISTER_NUMBER_WIDTH  = 5,
    parameter int REGISTER_WIDTH         = 64,
    parameter int INSTRUCTION_NAME_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stage3_valid,
    output logic                                stage3_ready,
    input  logic [REGISTER_WIDTH-1:0]           stage3_alu_result,
    input  logic [REGISTER_WIDTH-1:0]           stage3_rs2_val,
    input  logic [REGISTER_NUMBER_WIDTH:0]      stage3_rd,
    input  logic [INSTRUCTION_NAME_WIDTH*8:0]   stage3_opcode_name,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic                                mem_req_write,
    output logic [REGISTER_WIDTH-1:0]           mem_req_addr,
    output logic [REGISTER_WIDTH-1:0]           mem_req_wdata,
    output logic [7:0]                          mem_req_wstrb,
    input  logic                                mem_resp_valid,
    input  logic [REGISTER_WIDTH-1:0]           mem_resp_data,
    output logic                                stage4_valid,
    input  logic                                stage4_ready,
    output logic [REGISTER_NUMBER_WIDTH:0]      stage4_rd,
    output logic [REGISTER_WIDTH-1:0]           stage4_result,
    output logic [INSTRUCTION_NAME_WIDTH*8:0]   stage4_opcode_name,
    output logic                                stage4_misaligned,
    output logic [1:0]                          state_dbg
);

    localparam int RW = REGISTER_WIDTH;
    localparam int NW = INSTRUCTION_NAME_WIDTH*8+1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

    state_t                         state;
    logic [RW-1:0]                  addr_q;
    logic [REGISTER_NUMBER_WIDTH:0] rd_q;
    logic [NW-1:0]                  op_q;
    logic [1:0]                     size_q;
    logic                           store_q;
    logic                           uns_q;

    // Decode of the incoming opcode string.  Names are right-justified ASCII,
    // so every memory mnemonic lives in the low 3 bytes with zeros above.
    logic       dec_mem;
    logic       dec_store;
    logic [1:0] dec_size;   // 0=byte 1=half 2=word 3=double
    logic       dec_uns;
    logic       dec_aligned;
    logic [2:0] off;
    logic [7:0] size_mask;
    logic       accept;

    assign off = stage3_alu_result[2:0];

    always_comb begin
        dec_mem   = 1'b0;
        dec_store = 1'b0;
        dec_size  = 2'd0;
        dec_uns   = 1'b0;
        if (stage3_opcode_name[NW-1:24] == '0) begin
            case (stage3_opcode_name[23:0])
                {8'h00, "lb"}: begin dec_mem = 1'b1; dec_size = 2'd0; end
                {8'h00, "lh"}: begin dec_mem = 1'b1; dec_size = 2'd1; end
                {8'h00, "lw"}: begin dec_mem = 1'b1; dec_size = 2'd2; end
                {8'h00, "ld"}: begin dec_mem = 1'b1; dec_size = 2'd3; end
                "lbu":         begin dec_mem = 1'b1; dec_size = 2'd0; dec_uns = 1'b1; end
                "lhu":         begin dec_mem = 1'b1; dec_size = 2'd1; dec_uns = 1'b1; end
                "lwu":         begin dec_mem = 1'b1; dec_size = 2'd2; dec_uns = 1'b1; end
                {8'h00, "sb"}: begin dec_mem = 1'b1; dec_size = 2'd0; dec_store = 1'b1; end
                {8'h00, "sh"}: begin dec_mem = 1'b1; dec_size = 2'd1; dec_store = 1'b1; end
                {8'h00, "sw"}: begin dec_mem = 1'b1; dec_size = 2'd2; dec_store = 1'b1; end
                {8'h00, "sd"}: begin dec_mem = 1'b1; dec_size = 2'd3; dec_store = 1'b1; end
                default:       dec_mem = 1'b0;
            endcase
        end
    end

    always_comb begin
        dec_aligned = 1'b1;
        size_mask   = 8'h01;
        case (dec_size)
            2'd0: begin dec_aligned = 1'b1;            size_mask = 8'h01; end
            2'd1: begin dec_aligned = (off[0] == 1'b0); size_mask = 8'h03; end
            2'd2: begin dec_aligned = (off[1:0] == 2'b00); size_mask = 8'h0F; end
            default: begin dec_aligned = (off == 3'b000); size_mask = 8'hFF; end
        endcase
    end

    assign stage3_ready = (state == IDLE) || ((state == OUT) && stage4_ready);
    assign accept       = stage3_valid && stage3_ready;
    assign state_dbg    = state;

    // Shift the aligned doubleword down to the access offset, then truncate
    // to the access size and extend.
    function automatic logic [RW-1:0] load_value(input logic [RW-1:0] data,
                                                 input logic [2:0]    lane,
                                                 input logic [1:0]    size,
                                                 input logic          uns);
        logic [RW-1:0] sh;
        sh = data >> {lane, 3'b000};
        case (size)
            2'd0:    load_value = uns ? {{(RW-8){1'b0}}, sh[7:0]}   : {{(RW-8){sh[7]}}, sh[7:0]};
            2'd1:    load_value = uns ? {{(RW-16){1'b0}}, sh[15:0]} : {{(RW-16){sh[15]}}, sh[15:0]};
            2'd2:    load_value = uns ? {{(RW-32){1'b0}}, sh[31:0]} : {{(RW-32){sh[31]}}, sh[31:0]};
            default: load_value = sh;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            addr_q             <= '0;
            rd_q               <= '0;
            op_q               <= '0;
            size_q             <= '0;
            store_q            <= 1'b0;
            uns_q              <= 1'b0;
            mem_req_valid      <= 1'b0;
            mem_req_write      <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_wdata      <= '0;
            mem_req_wstrb      <= '0;
            stage4_valid       <= 1'b0;
            stage4_rd          <= '0;
            stage4_result      <= '0;
            stage4_opcode_name <= '0;
            stage4_misaligned  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state              <= OUT;
                        stage4_valid       <= 1'b1;
                        stage4_misaligned  <= 1'b0;
                        stage4_opcode_name <= op_q;
                        if (store_q) begin
                            stage4_rd     <= '0;
                            stage4_result <= addr_q;
                        end else begin
                            stage4_rd     <= rd_q;
                            stage4_result <= load_value(mem_resp_data, addr_q[2:0], size_q, uns_q);
                        end
                    end
                end
                OUT: begin
                    if (stage4_ready) begin
                        stage4_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: ;
            endcase

            // A new entry (only possible in IDLE or a draining OUT) overrides
            // the drain-to-IDLE decision above.
            if (accept) begin
                addr_q  <= stage3_alu_result;
                rd_q    <= stage3_rd;
                op_q    <= stage3_opcode_name;
                size_q  <= dec_size;
                store_q <= dec_store;
                uns_q   <= dec_uns;
                if (dec_mem && dec_aligned) begin
                    state         <= REQ;
                    stage4_valid  <= 1'b0;
                    mem_req_valid <= 1'b1;
                    mem_req_write <= dec_store;
                    mem_req_addr  <= {stage3_alu_result[RW-1:3], 3'b000};
                    mem_req_wdata <= dec_store ? (stage3_rs2_val << {off, 3'b000}) : '0;
                    mem_req_wstrb <= dec_store ? (size_mask << off) : 8'h00;
                end else begin
                    state              <= OUT;
                    stage4_valid       <= 1'b1;
                    stage4_opcode_name <= stage3_opcode_name;
                    stage4_misaligned  <= dec_mem;
                    stage4_result      <= stage3_alu_result;
                    stage4_rd          <= dec_mem ? '0 : stage3_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed bench for memory_stage.  A driver issues entries
// and pushes hand-computed expectations; a memory responder and a writeback
// monitor pop and compare whenever the DUT presents a request or a result.
module tb_memory_stage;

  localparam int RNW = 5;
  localparam int RW  = 64;
  localparam int INW = 12;
  localparam int NW  = INW*8+1;
  localparam int DW  = RNW+1;

  typedef struct {
    logic [DW-1:0] rd;
    logic [RW-1:0] result;
    logic [NW-1:0] name;
    logic          mis;
    int            lat;
    longint        t_acc;
  } s4_exp_t;

  typedef struct {
    logic          wr;
    logic [RW-1:0] addr;
    logic [RW-1:0] wdata;
    logic [7:0]    wstrb;
    logic [RW-1:0] resp;
  } mem_exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          stage3_valid;
  logic          stage3_ready;
  logic [RW-1:0] stage3_alu_result;
  logic [RW-1:0] stage3_rs2_val;
  logic [DW-1:0] stage3_rd;
  logic [NW-1:0] stage3_opcode_name;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_write;
  logic [RW-1:0] mem_req_addr;
  logic [RW-1:0] mem_req_wdata;
  logic [7:0]    mem_req_wstrb;
  logic          mem_resp_valid;
  logic [RW-1:0] mem_resp_data;
  logic          stage4_valid;
  logic          stage4_ready;
  logic [DW-1:0] stage4_rd;
  logic [RW-1:0] stage4_result;
  logic [NW-1:0] stage4_opcode_name;
  logic          stage4_misaligned;
  logic [1:0]    state_dbg;

  memory_stage #(
    .REGISTER_NUMBER_WIDTH(RNW),
    .REGISTER_WIDTH(RW),
    .INSTRUCTION_NAME_WIDTH(INW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stage3_valid(stage3_valid),
    .stage3_ready(stage3_ready),
    .stage3_alu_result(stage3_alu_result),
    .stage3_rs2_val(stage3_rs2_val),
    .stage3_rd(stage3_rd),
    .stage3_opcode_name(stage3_opcode_name),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .stage4_valid(stage4_valid),
    .stage4_ready(stage4_ready),
    .stage4_rd(stage4_rd),
    .stage4_result(stage4_result),
    .stage4_opcode_name(stage4_opcode_name),
    .stage4_misaligned(stage4_misaligned),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  s4_exp_t  exp_q[$];
  mem_exp_t mem_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout required completion", nm);
  endtask

  function automatic logic [NW-1:0] nm(input string s);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[NW-9:0], s[i]};
    return r;
  endfunction

  function automatic s4_exp_t s4e(input logic [DW-1:0] rd, input logic [RW-1:0] result,
                                  input string op, input logic mis, input int lat);
    s4_exp_t e;
    e.rd = rd; e.result = result; e.name = nm(op); e.mis = mis; e.lat = lat; e.t_acc = 0;
    return e;
  endfunction

  function automatic mem_exp_t me(input logic wr, input logic [RW-1:0] addr,
                                  input logic [RW-1:0] wdata, input logic [7:0] wstrb,
                                  input logic [RW-1:0] resp);
    mem_exp_t m;
    m.wr = wr; m.addr = addr; m.wdata = wdata; m.wstrb = wstrb; m.resp = resp;
    return m;
  endfunction

  // ---------------- memory responder ----------------
  logic     auto_mem = 1'b1;
  int       req_stall = 0;
  int       req_cnt = 0;
  logic     req_active = 1'b0;
  mem_exp_t cur_m;

  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem && !reset) begin
        mem_resp_valid = 1'b0;
        if (mem_req_ready) begin
          // handshake happened on the last edge: answer on the first WAIT cycle
          mem_req_ready  = 1'b0;
          mem_resp_valid = 1'b1;
          mem_resp_data  = cur_m.resp;
        end else if (mem_req_valid) begin
          if (!req_active) begin
            req_active = 1'b1;
            req_cnt    = 0;
            if (mem_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_mem_req: got addr 0x%0h required no request", mem_req_addr);
              cur_m = me(mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb, '0);
            end else begin
              cur_m = mem_q.pop_front();
            end
          end
          check("mem_req_write", mem_req_write, cur_m.wr);
          check("mem_req_addr", mem_req_addr, cur_m.addr);
          check("mem_req_wdata", mem_req_wdata, cur_m.wdata);
          check("mem_req_wstrb", mem_req_wstrb, cur_m.wstrb);
          check("s3_ready_busy", stage3_ready, 1'b0);
          if (req_cnt >= req_stall) begin
            mem_req_ready = 1'b1;
            req_active    = 1'b0;
            req_stall     = 0;
          end else begin
            req_cnt++;
          end
        end
      end
    end
  end

  // ---------------- writeback monitor ----------------
  int      s4_stall = 0;
  int      hold = 0;
  s4_exp_t cur_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && stage4_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_stage4: got result 0x%0h required no output", stage4_result);
          stage4_ready = 1'b1;
        end else begin
          cur_e = exp_q[0];
          if (hold == 0 && cur_e.lat > 0)
            check("latency", 128'(($time - 5 - cur_e.t_acc) / 10 + 1), 128'(cur_e.lat));
          check("s4_rd", stage4_rd, cur_e.rd);
          check("s4_result", stage4_result, cur_e.result);
          check("s4_name", stage4_opcode_name, cur_e.name);
          check("s4_misaligned", stage4_misaligned, cur_e.mis);
          if (hold < s4_stall) begin
            stage4_ready = 1'b0;
            hold++;
            #1;
            check("s3_ready_hold", stage3_ready, 1'b0);
          end else begin
            stage4_ready = 1'b1;
            void'(exp_q.pop_front());
            hold     = 0;
            s4_stall = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input string op, input logic [RW-1:0] alu, input logic [RW-1:0] rs2,
                       input logic [DW-1:0] rd, input logic push_s4, input s4_exp_t e,
                       input logic push_mem, input mem_exp_t m, output int waits);
    logic    acc;
    s4_exp_t e2;
    waits = 0;
    @(negedge clk);
    #1;
    stage3_valid       = 1'b1;
    stage3_opcode_name = nm(op);
    stage3_alu_result  = alu;
    stage3_rs2_val     = rs2;
    stage3_rd          = rd;
    forever begin
      #3;
      acc = stage3_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 100) begin
        fail_now("accept_timeout");
        stage3_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e2       = e;
    e2.t_acc = $time;
    if (push_s4) exp_q.push_back(e2);
    if (push_mem) mem_q.push_back(m);
    #1;
    stage3_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  s4_exp_t  e0;
  mem_exp_t m0;
  int       w;

  initial begin
    e0 = s4e('0, '0, "", 1'b0, 0);
    m0 = me(1'b0, '0, '0, '0, '0);
    reset              = 1'b1;
    stage3_valid       = 1'b0;
    stage3_alu_result  = '0;
    stage3_rs2_val     = '0;
    stage3_rd          = '0;
    stage3_opcode_name = '0;
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;
    stage4_ready       = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_s3_ready", stage3_ready, 1'b1);
    check("rst_s4_valid", stage4_valid, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_wstrb", mem_req_wstrb, 8'h00);
    check("rst_s4_result", stage4_result, '0);
    check("rst_state", state_dbg, 2'd0);
    reset = 1'b0;

    // pass-through, back to back (unknown mnemonic also passes through)
    issue("add", 64'h1234, '0, 6'd5, 1'b1, s4e(6'd5, 64'h1234, "add", 1'b0, 1), 1'b0, m0, w);
    issue("add", 64'h1, '0, 6'd6, 1'b1, s4e(6'd6, 64'h1, "add", 1'b0, 1), 1'b0, m0, w);
    check("b2b_accept_1", w, 0);
    issue("sub", 64'hFFFF_0000_0000_0002, '0, 6'd7, 1'b1,
          s4e(6'd7, 64'hFFFF_0000_0000_0002, "sub", 1'b0, 1), 1'b0, m0, w);
    check("b2b_accept_2", w, 0);
    issue("foo", 64'h3, '0, 6'd9, 1'b1, s4e(6'd9, 64'h3, "foo", 1'b0, 1), 1'b0, m0, w);
    check("b2b_accept_3", w, 0);
    drain();

    // loads/stores with lane alignment and extension
    issue("lb", 64'h1003, '0, 6'd10, 1'b1, s4e(6'd10, 64'hFFFF_FFFF_FFFF_FF80, "lb", 1'b0, 3),
          1'b1, me(1'b0, 64'h1000, '0, 8'h00, 64'h0000_0000_8000_0000), w);
    issue("lbu", 64'h1003, '0, 6'd11, 1'b1, s4e(6'd11, 64'h80, "lbu", 1'b0, 3),
          1'b1, me(1'b0, 64'h1000, '0, 8'h00, 64'h0000_0000_8000_0000), w);
    issue("sh", 64'h2006, 64'hABCD, 6'd12, 1'b1, s4e(6'd0, 64'h2006, "sh", 1'b0, 3),
          1'b1, me(1'b1, 64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, '0), w);
    issue("lw", 64'h3002, '0, 6'd13, 1'b1, s4e(6'd0, 64'h3002, "lw", 1'b1, 1), 1'b0, m0, w);
    issue("lh", 64'h5002, '0, 6'd16, 1'b1, s4e(6'd16, 64'hFFFF_FFFF_FFFF_F00D, "lh", 1'b0, 3),
          1'b1, me(1'b0, 64'h5000, '0, 8'h00, 64'h0000_0000_F00D_0000), w);
    issue("lwu", 64'h6004, '0, 6'd17, 1'b1, s4e(6'd17, 64'h89AB_CDEF, "lwu", 1'b0, 3),
          1'b1, me(1'b0, 64'h6000, '0, 8'h00, 64'h89AB_CDEF_0000_0000), w);
    issue("sb", 64'h7005, 64'h1FF, 6'd18, 1'b1, s4e(6'd0, 64'h7005, "sb", 1'b0, 3),
          1'b1, me(1'b1, 64'h7000, 64'h0001_FF00_0000_0000, 8'h20, '0), w);
    issue("sd", 64'h7004, 64'h55, 6'd19, 1'b1, s4e(6'd0, 64'h7004, "sd", 1'b1, 1), 1'b0, m0, w);
    issue("sd", 64'h7008, 64'hDEAD_BEEF_CAFE_F00D, 6'd20, 1'b1, s4e(6'd0, 64'h7008, "sd", 1'b0, 3),
          1'b1, me(1'b1, 64'h7008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, '0), w);
    drain();

    // ld with 3 cycles of request backpressure and 2 cycles of writeback stall
    req_stall = 3;
    s4_stall  = 2;
    issue("ld", 64'h4000, '0, 6'd14, 1'b1, s4e(6'd14, 64'h1122_3344_5566_7788, "ld", 1'b0, 6),
          1'b1, me(1'b0, 64'h4000, '0, 8'h00, 64'h1122_3344_5566_7788), w);
    drain();

    // reset while waiting for the response; a stale response must be ignored
    auto_mem       = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    issue("ld", 64'h8000, '0, 6'd15, 1'b0, e0, 1'b0, m0, w);
    @(negedge clk);
    check("wr_req_valid", mem_req_valid, 1'b1);
    check("wr_req_addr", mem_req_addr, 64'h8000);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("wr_state_wait", state_dbg, 2'd2);
    #1;
    reset = 1'b1;
    #1;
    check("wr_rst_state", state_dbg, 2'd0);
    check("wr_rst_req_valid", mem_req_valid, 1'b0);
    check("wr_rst_req_addr", mem_req_addr, '0);
    check("wr_rst_s3_ready", stage3_ready, 1'b1);
    check("wr_rst_s4_valid", stage4_valid, 1'b0);
    @(negedge clk);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wr_after_state", state_dbg, 2'd0);
    check("wr_after_s4_valid", stage4_valid, 1'b0);
    auto_mem = 1'b1;

    // recovery after reset
    issue("xor", 64'hC0FFEE, '0, 6'd21, 1'b1, s4e(6'd21, 64'hC0FFEE, "xor", 1'b0, 1), 1'b0, m0, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the combinational execute stage. Registers the execute outputs: ALU result/address, rs2 value, rd, and the opcode name string.
- Performs load/store accesses over a valid/ready request + response data port, with byte-lane alignment and sign/zero extension.
- Non-memory instructions pass through. Results go to the writeback stage with a valid/ready handshake.

Parameters:
REGISTER_NUMBER_WIDTH, 5, rd field is [REGISTER_NUMBER_WIDTH:0]
REGISTER_WIDTH, 64, data/address width
INSTRUCTION_NAME_WIDTH, 12, opcode name string is [INSTRUCTION_NAME_WIDTH*8:0], ASCII, right-justified

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stage3_valid  in  1  execute-side entry valid
stage3_ready  out  1  stage can accept an entry
stage3_alu_result  in  REGISTER_WIDTH  ALU result, or effective address for loads/stores
stage3_rs2_val  in  REGISTER_WIDTH  store data
stage3_rd  in  REGISTER_NUMBER_WIDTH+1  destination register
stage3_opcode_name  in  INSTRUCTION_NAME_WIDTH*8+1  opcode string
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=store, 0=load
mem_req_addr  out  REGISTER_WIDTH  8-byte aligned address (addr[2:0]=0)
mem_req_wdata  out  REGISTER_WIDTH  lane-shifted store data
mem_req_wstrb  out  8  byte enables
mem_resp_valid  in  1  read data / store ack, one cycle
mem_resp_data  in  REGISTER_WIDTH  aligned 8-byte read data
stage4_valid  out  1  writeback entry valid
stage4_ready  in  1  writeback accepts
stage4_rd  out  REGISTER_NUMBER_WIDTH+1  destination; 0 for stores
stage4_result  out  REGISTER_WIDTH  final value
stage4_opcode_name  out  INSTRUCTION_NAME_WIDTH*8+1  opcode string passthrough
stage4_misaligned  out  1  misaligned access flag

Behaviour:
- States: IDLE, REQ, WAIT, OUT. Reset (async, any state, including mid-request) → IDLE.
- Reset values: all stage4_* outputs, mem_req_* outputs and internal registers = 0; stage3_ready=1.
- stage3_ready = (state==IDLE) || (state==OUT && stage4_ready).
- An entry is accepted on the clock edge where stage3_valid && stage3_ready; all stage3 inputs are captured.
- Accepted entry routing:
  - Memory op (lb lh lw ld lbu lhu lwu sb sh sw sd), aligned → REQ.
  - Misaligned memory op, or any other opcode → OUT directly.
  - Non-memory opcodes: result = alu_result, 1-cycle latency.
- Alignment rules, with off = addr[2:0]:
  - Byte ops: any offset.
  - h ops: off[0]=0.
  - w ops: off[1:0]=0.
  - d ops: off=0.
  - Violation: no memory access; OUT with stage4_misaligned=1, stage4_result=address, stage4_rd=0.
- REQ:
  - mem_req_valid=1.
  - mem_req_addr = {addr[63:3],3'b0}.
  - Store: mem_req_wdata = rs2 << (8*off); wstrb = size mask (b:1, h:3, w:F, d:FF) << off.
  - Load: wstrb=0, wdata=0.
  - All mem_req_* fields are held stable until mem_req_ready; the handshake edge → WAIT. mem_req_valid drops the next cycle.
- WAIT:
  - Waits for mem_resp_valid, then → OUT.
  - Load result: (mem_resp_data >> 8*off), truncated to size, then sign-extended (lb/lh/lw/ld) or zero-extended (lbu/lhu/lwu).
  - Store result = address; rd=0.
- mem_resp_valid outside WAIT is ignored. This covers a stale response after reset.
- OUT:
  - stage4_valid=1; outputs are held stable until stage4_ready.
  - On the stage4_ready edge: if a new entry is accepted in the same cycle, the next state follows the new entry's routing; otherwise → IDLE with stage4_valid=0.
- Latency, accept to stage4_valid:
  - Non-memory: 1 cycle.
  - Memory: 3 cycles, with mem_req_ready and mem_resp_valid each asserted on their first possible cycle.
- At most one outstanding memory request; no new accept during REQ/WAIT.
- Unknown opcode strings are treated as non-memory passthrough.

Test Plan:
- "add", alu_result=0x1234, rd=5, stage4_ready=1 → stage4_valid one cycle later, result=0x1234, rd=5, misaligned=0; back-to-back adds accepted every cycle.
- "lb", addr=0x1003, mem_resp_data=0x00000000_80000000 → mem_req_addr=0x1000, wstrb=0; result=0xFFFFFFFF_FFFFFF80. Same with "lbu" → 0x80.
- "sh", addr=0x2006, rs2=0xABCD → mem_req_write=1, addr=0x2000, wdata=0xABCD000000000000, wstrb=0xC0; stage4_rd=0.
- "lw", addr=0x3002 → no mem_req_valid; stage4_misaligned=1, result=0x3002.
- "ld", mem_req_ready low for 3 cycles and stage4_ready low for 2 cycles → request fields stable throughout, stage4 outputs held, stage3_ready=0 until drain.
- Reset asserted during WAIT, then mem_resp_valid=1 after release → state IDLE, outputs 0, response ignored, no stage4_valid.
